// File: rtl/word_write_arbiter_pkg.sv
// Shared types and constants for the word write arbiter and its round-robin selector.
package word_write_arbiter_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    localparam int WORD_BYTES_DEFAULT = 4;

    // Highest fill level that still leaves room for the word being started plus
    // one word whose bytes are not yet reflected in the fill level.
    function automatic int space_limit(input int pointer_width, input int word_bytes);
        return (2 ** pointer_width) - 1 - (2 * word_bytes);
    endfunction

endpackage

// File: rtl/word_write_arbiter_rr_select.sv
// Round-robin one-hot selector: the first set request at or after the pointer wins.
module rr_select #(
    parameter int REQUESTERS = 4,
    parameter int PTR_W      = 2
) (
    input  logic [REQUESTERS-1:0] request,
    input  logic [PTR_W-1:0]      pointer,
    output logic [REQUESTERS-1:0] grant
);

    // Scan from the pointer upward with wrap and keep only the first hit.
    always_comb begin
        logic             found;
        logic             hit;
        logic [PTR_W-1:0] idx;
        grant = '0;
        found = 1'b0;
        hit   = 1'b0;
        idx   = '0;
        for (int i = 0; i < REQUESTERS; i++) begin
            idx        = PTR_W'((int'(pointer) + i) % REQUESTERS);
            hit        = !found && request[idx];
            grant[idx] = grant[idx] | hit;
            found      = found | hit;
        end
    end

endmodule

// File: rtl/word_write_arbiter.sv
// Arbitrates whole words from several byte sources into one deserializer byte stream,
// sending one word per grant and never starting a word without FIFO headroom.
module word_write_arbiter
    import word_write_arbiter_pkg::*;
#(
    parameter int DATA_WIDTH    = 8,
    parameter int POINTER_WIDTH = 8,
    parameter int REQUESTERS    = 4,
    parameter int WORD_BYTES    = WORD_BYTES_DEFAULT
) (
    input  logic                                  sender_clock,
    input  logic                                  sender_reset,
    input  logic [REQUESTERS-1:0]                 request,
    input  logic [REQUESTERS-1:0][DATA_WIDTH-1:0] request_data,
    output logic [REQUESTERS-1:0]                 grant,
    output logic [REQUESTERS-1:0]                 byte_ack,
    input  logic [POINTER_WIDTH-1:0]              data_in_used,
    output logic                                  data_in_enable,
    output logic [DATA_WIDTH-1:0]                 data_in,
    output logic                                  busy,
    output logic [15:0]                           words_sent
);

    localparam int CNT_W       = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;
    localparam int PTR_W       = (REQUESTERS > 1) ? $clog2(REQUESTERS) : 1;
    localparam int SPACE_LIMIT = space_limit(POINTER_WIDTH, WORD_BYTES);
    localparam logic [CNT_W-1:0] LAST_BYTE = CNT_W'(WORD_BYTES - 1);

    state_t                  state_q, state_d;
    logic [REQUESTERS-1:0]   grant_q, grant_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [PTR_W-1:0]        ptr_q, ptr_d;
    logic                    den_q, den_d;
    logic [DATA_WIDTH-1:0]   din_q, din_d;
    logic [15:0]             words_q, words_d;

    logic [REQUESTERS-1:0]   sel_grant_s;
    logic [PTR_W-1:0]        sel_idx_s;
    logic [PTR_W-1:0]        owner_idx_s;
    logic                    space_ok_s;

    rr_select #(
        .REQUESTERS (REQUESTERS),
        .PTR_W      (PTR_W)
    ) u_rr_select (
        .request (request),
        .pointer (ptr_q),
        .grant   (sel_grant_s)
    );

    assign space_ok_s = (int'(data_in_used) <= SPACE_LIMIT);

    // One-hot to index for both the candidate grant and the current owner.
    always_comb begin
        sel_idx_s   = '0;
        owner_idx_s = '0;
        for (int i = 0; i < REQUESTERS; i++) begin
            sel_idx_s   = sel_grant_s[i] ? PTR_W'(i) : sel_idx_s;
            owner_idx_s = grant_q[i]     ? PTR_W'(i) : owner_idx_s;
        end
    end

    // Next-state logic; a started word always runs to completion.
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        cnt_d   = cnt_q;
        ptr_d   = ptr_q;
        den_d   = 1'b0;
        din_d   = din_q;
        words_d = words_q;
        case (state_q)
            IDLE: begin
                if ((|request) && space_ok_s) begin
                    grant_d = sel_grant_s;
                    cnt_d   = '0;
                    ptr_d   = (sel_idx_s == PTR_W'(REQUESTERS - 1)) ? '0 : sel_idx_s + PTR_W'(1);
                    state_d = SEND;
                end else begin
                    grant_d = '0;
                end
            end
            SEND: begin
                den_d = 1'b1;
                din_d = request_data[owner_idx_s];
                if (cnt_q == LAST_BYTE) begin
                    state_d = IDLE;
                    grant_d = '0;
                    cnt_d   = '0;
                    words_d = words_q + 16'd1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                grant_d = '0;
            end
        endcase
    end

    // State and registered outputs; reset abandons any partial word.
    always_ff @(posedge sender_clock) begin
        if (sender_reset) begin
            state_q <= IDLE;
            grant_q <= '0;
            cnt_q   <= '0;
            ptr_q   <= '0;
            den_q   <= 1'b0;
            din_q   <= '0;
            words_q <= 16'd0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            cnt_q   <= cnt_d;
            ptr_q   <= ptr_d;
            den_q   <= den_d;
            din_q   <= din_d;
            words_q <= words_d;
        end
    end

    assign grant          = grant_q;
    assign byte_ack       = (state_q == SEND) ? grant_q : '0;
    assign data_in_enable = den_q;
    assign data_in        = din_q;
    assign busy           = (state_q == SEND);
    assign words_sent     = words_q;

endmodule
